// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for the two-requester SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned SPA_BUS_WIDTH  = 32;
    localparam int unsigned SPA_DATA_WIDTH = 32;
    localparam int unsigned SPA_LOCK_MAX   = 16;

    // Identifies one of the two requesters (pointer side, lock owner).
    typedef enum logic {
        OwnP0 = 1'b0,
        OwnP1 = 1'b1
    } owner_e;

    function automatic owner_e other_owner(owner_e o);
        return (o == OwnP0) ? OwnP1 : OwnP0;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with burst lock and a forced handover after LOCK_MAX
// consecutive locked grants. The winner is exposed before the stall qualifier so the
// parent can veto a grant without disturbing pointer, owner or counter.
module sram_port_arbiter_rr_arb2
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_MAX = SPA_LOCK_MAX
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       stall_i,
    output logic [1:0] win_o,
    output logic [1:0] gnt_o
);

    localparam int unsigned     CntW    = $clog2(LOCK_MAX + 1);
    // A locked grant taken while the counter sits here is the LOCK_MAX-th one.
    localparam logic [CntW-1:0] CntLast = CntW'(LOCK_MAX - 1);
    localparam logic [CntW-1:0] CntSat  = {CntW{1'b1}};

    owner_e          ptr_q, ptr_d;
    owner_e          owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    owner_e          gidx;
    logic            glock;

    // Pick the candidate: lock owner only, else the sole requester, else the pointer side.
    always_comb begin
        win_o = 2'b00;
        if (owner_vld_q) begin
            if (owner_q == OwnP1) begin
                win_o[1] = req_i[1];
            end else begin
                win_o[0] = req_i[0];
            end
        end else if (req_i == 2'b11) begin
            win_o = (ptr_q == OwnP1) ? 2'b10 : 2'b01;
        end else begin
            win_o = req_i;
        end
        gnt_o = stall_i ? 2'b00 : win_o;
    end

    // Pointer, lock owner and counter move only on a real (non-stalled) grant.
    always_comb begin
        gidx        = gnt_o[1] ? OwnP1 : OwnP0;
        glock       = gnt_o[1] ? lock_i[1] : lock_i[0];
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        cnt_d       = cnt_q;
        if (|gnt_o) begin
            if (glock && (cnt_q < CntLast)) begin
                owner_vld_d = 1'b1;
                owner_d     = gidx;
                cnt_d       = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
            end else begin
                // Burst end or forced handover: drop the lock and favour the other side.
                owner_vld_d = 1'b0;
                cnt_d       = '0;
                ptr_d       = other_owner(gidx);
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= OwnP0;
            owner_q     <= OwnP0;
            owner_vld_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares a simple-dual-port SRAM between two requesters. Read and write ports are
// arbitrated independently; a read hitting the word being written this cycle waits one
// cycle so it returns the new data. Read data is steered back via a registered owner tag.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = SPA_BUS_WIDTH,
    parameter int unsigned DATA_WIDTH = SPA_DATA_WIDTH,
    parameter int unsigned LOCK_MAX   = SPA_LOCK_MAX
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    p0_ren,
    input  logic [BUS_WIDTH-1:0]    p0_raddr,
    input  logic                    p0_rlock,
    output logic                    p0_rgnt,
    output logic [DATA_WIDTH-1:0]   p0_rdata,
    output logic                    p0_rvalid,
    input  logic [DATA_WIDTH/8-1:0] p0_wen,
    input  logic [BUS_WIDTH-1:0]    p0_waddr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    input  logic                    p0_wlock,
    output logic                    p0_wgnt,
    input  logic                    p1_ren,
    input  logic [BUS_WIDTH-1:0]    p1_raddr,
    input  logic                    p1_rlock,
    output logic                    p1_rgnt,
    output logic [DATA_WIDTH-1:0]   p1_rdata,
    output logic                    p1_rvalid,
    input  logic [DATA_WIDTH/8-1:0] p1_wen,
    input  logic [BUS_WIDTH-1:0]    p1_waddr,
    input  logic [DATA_WIDTH-1:0]   p1_wdata,
    input  logic                    p1_wlock,
    output logic                    p1_wgnt,
    output logic [BUS_WIDTH-1:0]    ram_raddr,
    output logic                    ram_ren,
    input  logic [DATA_WIDTH-1:0]   ram_rdata,
    output logic [BUS_WIDTH-1:0]    ram_waddr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_wen
);

    logic [1:0]           rreq, rlock, rwin, rgnt;
    logic [1:0]           wreq, wlock, wwin, wgnt;
    logic [BUS_WIDTH-3:0] rwin_word, wwin_word;
    logic                 collide;
    logic [1:0]           rvalid_q;

    // Request decode; a write request is any set byte strobe.
    always_comb begin
        rreq  = {p1_ren, p0_ren};
        rlock = {p1_rlock, p0_rlock};
        wreq  = {|p1_wen, |p0_wen};
        wlock = {p1_wlock, p0_wlock};
    end

    // Same-word compare between read winner and write winner (the write port never stalls).
    always_comb begin
        rwin_word = rwin[1] ? p1_raddr[BUS_WIDTH-1:2] : p0_raddr[BUS_WIDTH-1:2];
        wwin_word = wwin[1] ? p1_waddr[BUS_WIDTH-1:2] : p0_waddr[BUS_WIDTH-1:2];
        collide   = (|rwin) && (|wwin) && (rwin_word == wwin_word);
    end

    sram_port_arbiter_rr_arb2 #(
        .LOCK_MAX(LOCK_MAX)
    ) u_rd_arb (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .req_i  (rreq),
        .lock_i (rlock),
        .stall_i(collide),
        .win_o  (rwin),
        .gnt_o  (rgnt)
    );

    sram_port_arbiter_rr_arb2 #(
        .LOCK_MAX(LOCK_MAX)
    ) u_wr_arb (
        .clk_i  (aclk),
        .rst_ni (aresetn),
        .req_i  (wreq),
        .lock_i (wlock),
        .stall_i(1'b0),
        .win_o  (wwin),
        .gnt_o  (wgnt)
    );

    // SRAM-side muxes; idle ports drive zero.
    always_comb begin
        ram_ren   = |rgnt;
        ram_raddr = '0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_wen   = '0;
        if (rgnt[1]) begin
            ram_raddr = p1_raddr;
        end else if (rgnt[0]) begin
            ram_raddr = p0_raddr;
        end
        if (wgnt[1]) begin
            ram_waddr = p1_waddr;
            ram_wdata = p1_wdata;
            ram_wen   = p1_wen;
        end else if (wgnt[0]) begin
            ram_waddr = p0_waddr;
            ram_wdata = p0_wdata;
            ram_wen   = p0_wen;
        end
    end

    // Requester-side outputs; read data is shared and qualified by each rvalid.
    always_comb begin
        p0_rgnt   = rgnt[0];
        p1_rgnt   = rgnt[1];
        p0_wgnt   = wgnt[0];
        p1_wgnt   = wgnt[1];
        p0_rvalid = rvalid_q[0];
        p1_rvalid = rvalid_q[1];
        p0_rdata  = ram_rdata;
        p1_rdata  = ram_rdata;
    end

    // Owner tag of the read issued this cycle; reset discards an in-flight read.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= 2'b00;
        end else begin
            rvalid_q <= rgnt;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected grant vectors and read returns into queues,
// an independent monitor pops and compares whenever the DUT grants or returns data.
module tb_sram_port_arbiter;

    localparam logic [3:0] P0R = 4'b0001;
    localparam logic [3:0] P1R = 4'b0010;
    localparam logic [3:0] P0W = 4'b0100;
    localparam logic [3:0] P1W = 4'b1000;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] data;
    } rd_t;

    logic        aclk, aresetn;
    logic        p0_ren, p0_rlock, p0_rgnt, p0_rvalid, p0_wlock, p0_wgnt;
    logic [31:0] p0_raddr, p0_rdata, p0_waddr, p0_wdata;
    logic [3:0]  p0_wen;
    logic        p1_ren, p1_rlock, p1_rgnt, p1_rvalid, p1_wlock, p1_wgnt;
    logic [31:0] p1_raddr, p1_rdata, p1_waddr, p1_wdata;
    logic [3:0]  p1_wen;
    logic [31:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
    logic        ram_ren;
    logic [3:0]  ram_wen;

    logic [3:0]  gv;
    logic [1:0]  rv;
    logic [3:0]  gq[$];
    rd_t         rq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mem_fill;
    logic [31:0] mem [0:255];

    assign gv = {p1_wgnt, p0_wgnt, p1_rgnt, p0_rgnt};
    assign rv = {p1_rvalid, p0_rvalid};

    sram_port_arbiter #(
        .BUS_WIDTH (32),
        .DATA_WIDTH(32),
        .LOCK_MAX  (16)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .p0_ren   (p0_ren),
        .p0_raddr (p0_raddr),
        .p0_rlock (p0_rlock),
        .p0_rgnt  (p0_rgnt),
        .p0_rdata (p0_rdata),
        .p0_rvalid(p0_rvalid),
        .p0_wen   (p0_wen),
        .p0_waddr (p0_waddr),
        .p0_wdata (p0_wdata),
        .p0_wlock (p0_wlock),
        .p0_wgnt  (p0_wgnt),
        .p1_ren   (p1_ren),
        .p1_raddr (p1_raddr),
        .p1_rlock (p1_rlock),
        .p1_rgnt  (p1_rgnt),
        .p1_rdata (p1_rdata),
        .p1_rvalid(p1_rvalid),
        .p1_wen   (p1_wen),
        .p1_waddr (p1_waddr),
        .p1_wdata (p1_wdata),
        .p1_wlock (p1_wlock),
        .p1_wgnt  (p1_wgnt),
        .ram_raddr(ram_raddr),
        .ram_ren  (ram_ren),
        .ram_rdata(ram_rdata),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .ram_wen  (ram_wen)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // SRAM model: 1-cycle read latency, byte-strobed write, word i preset to A000_0000+i.
    always @(posedge aclk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else begin
            if (ram_ren) ram_rdata <= mem[ram_raddr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) mem[ram_waddr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // Monitor: every grant vector and every read return is popped and compared.
    initial begin : monitor
        logic [3:0] eg;
        rd_t        er;
        logic [31:0] rd;
        forever begin
            @(negedge aclk);
            if (gv != 4'b0000) begin
                n_cmp++;
                if (gq.size() == 0) begin
                    n_bad++;
                    $display("FAIL gnt_unexpected: got %b, required no grant", gv);
                end else begin
                    eg = gq.pop_front();
                    if (gv !== eg) begin
                        n_bad++;
                        $display("FAIL gnt_vector: got %b, required %b", gv, eg);
                    end
                end
            end
            if (rv != 2'b00) begin
                rd = rv[1] ? p1_rdata : p0_rdata;
                n_cmp++;
                if (rq.size() == 0) begin
                    n_bad++;
                    $display("FAIL rvalid_unexpected: got rvalid=%b data=%h, required none", rv, rd);
                end else begin
                    er = rq.pop_front();
                    if ({rv, rd} !== {er.who, er.data}) begin
                        n_bad++;
                        $display("FAIL read_return: got rvalid=%b data=%h, required rvalid=%b data=%h",
                                 rv, rd, er.who, er.data);
                    end
                end
            end
        end
    end

    task automatic check_idle(input string nm);
        n_cmp++;
        if ({gv, rv, ram_ren, ram_wen, ram_raddr, ram_waddr, ram_wdata} !== '0) begin
            n_bad++;
            $display("FAIL %s: gnt=%b rvalid=%b ren=%b wen=%b raddr=%h waddr=%h wdata=%h, required all 0",
                     nm, gv, rv, ram_ren, ram_wen, ram_raddr, ram_waddr, ram_wdata);
        end
    endtask

    // Holds every raised request until its grant is seen, within a cycle budget.
    task automatic settle(input int budget, input string nm);
        logic [3:0] g;
        int n = 0;
        while ((p0_ren || p1_ren || (|p0_wen) || (|p1_wen)) && n < budget) begin
            @(negedge aclk);
            g = gv;
            @(posedge aclk);
            #1;
            if (g[0]) p0_ren = 1'b0;
            if (g[1]) p1_ren = 1'b0;
            if (g[2]) p0_wen = 4'h0;
            if (g[3]) p1_wen = 4'h0;
            n++;
        end
        n_cmp++;
        if (p0_ren || p1_ren || (|p0_wen) || (|p1_wen)) begin
            n_bad++;
            $display("FAIL %s_timeout: requests pending after %0d cycles, required all granted", nm, budget);
            p0_ren = 1'b0; p1_ren = 1'b0; p0_wen = 4'h0; p1_wen = 4'h0;
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    initial begin : watchdog
        #20000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int i0, i1, beat;
        logic p0_done;
        logic [3:0] g;
        aresetn = 1'b0; mem_fill = 1'b1;
        p0_ren = 0; p0_raddr = 0; p0_rlock = 0; p0_wen = 0; p0_waddr = 0; p0_wdata = 0; p0_wlock = 0;
        p1_ren = 0; p1_raddr = 0; p1_rlock = 0; p1_wen = 0; p1_waddr = 0; p1_wdata = 0; p1_wlock = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_idle("reset_state");
        #2;
        aresetn = 1'b1; mem_fill = 1'b0;
        drain(1);

        // 1. Reset while a read is in flight: no rvalid may follow.
        gq.push_back(P0R);
        p0_raddr = 32'h0; p0_ren = 1'b1;
        @(negedge aclk);
        @(posedge aclk);
        #1;
        p0_ren = 1'b0; aresetn = 1'b0;
        @(negedge aclk);
        check_idle("reset_mid_read");
        @(negedge aclk);
        #2;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        check_idle("post_reset_idle");
        drain(1);

        // 2. Read contention without lock alternates p0,p1,p0,p1.
        gq.push_back(P0R); gq.push_back(P1R); gq.push_back(P0R); gq.push_back(P1R);
        rq.push_back('{2'b01, 32'hA000_0040}); rq.push_back('{2'b10, 32'hA000_0080});
        rq.push_back('{2'b01, 32'hA000_0041}); rq.push_back('{2'b10, 32'hA000_0081});
        i0 = 0; i1 = 0;
        p0_raddr = 32'h100; p0_ren = 1'b1;
        p1_raddr = 32'h200; p1_ren = 1'b1;
        for (int c = 0; c < 12 && (i0 < 2 || i1 < 2); c++) begin
            @(negedge aclk);
            g = gv;
            @(posedge aclk);
            #1;
            if (g[0]) begin i0++; if (i0 < 2) p0_raddr = 32'h104; else p0_ren = 1'b0; end
            if (g[1]) begin i1++; if (i1 < 2) p1_raddr = 32'h204; else p1_ren = 1'b0; end
        end
        n_cmp++;
        if (i0 != 2 || i1 != 2) begin
            n_bad++;
            $display("FAIL contention_timeout: grants p0=%0d p1=%0d, required 2 each", i0, i1);
            p0_ren = 1'b0; p1_ren = 1'b0;
        end
        drain(3);

        // 3. p1 locked write burst of 20; p0 gets in after 16 grants, then p1 resumes.
        for (int k = 0; k < 16; k++) gq.push_back(P1W);
        gq.push_back(P0W);
        for (int k = 0; k < 4; k++) gq.push_back(P1W);
        beat = 0; p0_done = 1'b0;
        p1_wen = 4'hF; p1_waddr = 32'h300; p1_wdata = 32'h0; p1_wlock = 1'b1;
        for (int c = 0; c < 40 && (beat < 20 || !p0_done); c++) begin
            @(negedge aclk);
            g = gv;
            @(posedge aclk);
            #1;
            if (c == 0) begin
                p0_wen = 4'hF; p0_waddr = 32'h3F0; p0_wdata = 32'h0BAD_F00D; p0_wlock = 1'b0;
            end
            if (g[2]) begin p0_wen = 4'h0; p0_done = 1'b1; end
            if (g[3]) begin
                beat++;
                if (beat < 20) begin
                    p1_waddr = 32'h300 + 32'(4 * beat);
                    p1_wdata = 32'(beat);
                    p1_wlock = (beat != 19);
                end else begin
                    p1_wen = 4'h0; p1_wlock = 1'b0;
                end
            end
        end
        n_cmp++;
        if (beat != 20 || !p0_done) begin
            n_bad++;
            $display("FAIL burst_timeout: p1 beats=%0d p0 done=%b, required 20 and 1", beat, p0_done);
            p0_wen = 4'h0; p1_wen = 4'h0; p1_wlock = 1'b0;
        end
        drain(2);

        // 4. Same-word read/write collision: read waits a cycle and sees the new data.
        gq.push_back(P1W); gq.push_back(P0R);
        rq.push_back('{2'b01, 32'hDEAD_BEEF});
        p1_wen = 4'hF; p1_waddr = 32'h40; p1_wdata = 32'hDEAD_BEEF;
        p0_ren = 1'b1; p0_raddr = 32'h40;
        settle(8, "collision");
        drain(2);

        // 5. Byte strobes merge into an all-ones word.
        gq.push_back(P1W);
        p1_wen = 4'hF; p1_waddr = 32'h80; p1_wdata = 32'hFFFF_FFFF;
        settle(8, "strobe_fill");
        gq.push_back(P0W);
        p0_wen = 4'b0011; p0_waddr = 32'h80; p0_wdata = 32'h1122_3344;
        settle(8, "strobe_write");
        gq.push_back(P0R);
        rq.push_back('{2'b01, 32'hFFFF_3344});
        p0_ren = 1'b1; p0_raddr = 32'h80;
        settle(8, "strobe_read");
        drain(2);

        // 6. Different words: read and write granted in the same cycle.
        gq.push_back(P1W | P0R);
        rq.push_back('{2'b01, 32'hA000_0004});
        p0_ren = 1'b1; p0_raddr = 32'h10;
        p1_wen = 4'hF; p1_waddr = 32'h20; p1_wdata = 32'h55AA_55AA;
        settle(8, "dual_port");
        gq.push_back(P1R);
        rq.push_back('{2'b10, 32'h55AA_55AA});
        p1_ren = 1'b1; p1_raddr = 32'h20;
        settle(8, "dual_readback");
        drain(3);

        n_cmp++;
        if (gq.size() != 0) begin
            n_bad++;
            $display("FAIL gnt_missing: %0d expected grants outstanding, required 0", gq.size());
        end
        n_cmp++;
        if (rq.size() != 0) begin
            n_bad++;
            $display("FAIL read_missing: %0d expected returns outstanding, required 0", rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
